// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Instruction fetches are word aligned; redirect targets drop their low bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: instruction memory, hazard controls, redirects and IF/ID outputs.
interface if_fetch_stage_if;
    import mips_pkg::*;

    logic [31:0]        pc;
    logic [31:0]        pc_4;
    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               flush;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic               jump;
    logic [31:0]        jump_target;
    logic [INSTR_W-1:0] ifid_instr;
    logic [31:0]        ifid_pc_4;
    logic               ifid_valid;

    modport master (
        output pc, imem_req, imem_addr, ifid_instr, ifid_pc_4, ifid_valid,
        input  pc_4, imem_ready, imem_rdata, stall, flush,
               branch_taken, branch_target, jump, jump_target
    );

    modport slave (
        input  pc, imem_req, imem_addr, ifid_instr, ifid_pc_4, ifid_valid,
        output pc_4, imem_ready, imem_rdata, stall, flush,
               branch_taken, branch_target, jump, jump_target
    );

endinterface

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register; flush beats stall, stall beats load.
module ifid_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               stall,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [31:0]        pc_4_in,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc_4,
    output logic               valid
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc_4_q,  pc_4_d;
    logic               valid_q, valid_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        instr_d = instr_q;
        pc_4_d  = pc_4_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc_4_d  = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (!stall && load) begin
            instr_d = instr_in;
            pc_4_d  = pc_4_in;
            valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_4_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_4_q  <= pc_4_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc_4  = pc_4_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, imem request,
// one-entry hold buffer for words returning under stall, and the IF/ID register.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_stage_if.master bus
);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic [31:0]        buf_pc_4_q, buf_pc_4_d;

    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               ifid_load;
    logic [INSTR_W-1:0] ifid_instr_in;
    logic [31:0]        ifid_pc_4_in;

    // Redirects are ignored in IDLE; branch wins over jump.
    assign redirect    = (bus.branch_taken || bus.jump) && (state_q != IDLE);
    assign redirect_pc = align_word(bus.branch_taken ? bus.branch_target : bus.jump_target);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_4_d    = buf_pc_4_q;
        ifid_load     = 1'b0;
        ifid_instr_in = bus.imem_rdata;
        ifid_pc_4_in  = bus.pc_4;

        case (state_q)
            IDLE: state_d = FETCH;

            FETCH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (bus.imem_ready) begin
                    pc_d = bus.pc_4;
                    if (bus.stall) begin
                        buf_instr_d = bus.imem_rdata;
                        buf_pc_4_d  = bus.pc_4;
                        state_d     = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end
            end

            HOLD: begin
                // Leaving HOLD on a redirect simply abandons the buffered word.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (!bus.stall) begin
                    ifid_load     = 1'b1;
                    ifid_instr_in = buf_instr_q;
                    ifid_pc_4_in  = buf_pc_4_q;
                    state_d       = FETCH;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the hold buffer is a couple of plain flops, so it is reset like any other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
            buf_pc_4_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_4_q  <= buf_pc_4_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .stall    (bus.stall),
        .flush    (bus.flush),
        .instr_in (ifid_instr_in),
        .pc_4_in  (ifid_pc_4_in),
        .instr    (bus.ifid_instr),
        .pc_4     (bus.ifid_pc_4),
        .valid    (bus.ifid_valid)
    );

    assign bus.pc        = pc_q;
    assign bus.imem_addr = pc_q;
    assign bus.imem_req  = (state_q == FETCH);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized run
// compared against a queue-based behavioural model of the fetch stage.
module tb_if_fetch_stage;
    import mips_pkg::*;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External PC+4 adder and a deterministic instruction memory.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.pc_4       = bus.pc + 32'd4;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    // Reference model: a started flag, the PC, and a queue of fetched words not yet in IF/ID.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } word_t;

    bit          m_started;
    logic [31:0] m_pc;
    word_t       m_pend[$];
    logic [31:0] m_ii, m_ip4;
    logic        m_iv;

    function automatic logic m_req();
        return m_started && (m_pend.size() == 0);
    endfunction

    task automatic model_update();
        word_t       w;
        logic [31:0] tgt;
        bit          have;
        if (rst) begin
            m_started = 0;
            m_pc      = RPC;
            m_pend.delete();
            m_ii = 0; m_ip4 = 0; m_iv = 0;
            return;
        end
        have = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (bus.branch_taken || bus.jump) begin
            tgt = bus.branch_taken ? bus.branch_target : bus.jump_target;
            m_pc = tgt & 32'hFFFF_FFFC;
            m_pend.delete();
        end else begin
            if (m_pend.size() == 0 && bus.imem_ready) begin
                w.instr = mem_word(m_pc);
                w.pc4   = m_pc + 32'd4;
                m_pend.push_back(w);
                m_pc = m_pc + 32'd4;
            end
            if (!bus.stall && m_pend.size() > 0) begin
                w    = m_pend.pop_front();
                have = 1;
            end
        end
        if (bus.flush) begin
            m_ii = 0; m_ip4 = 0; m_iv = 0;
        end else if (have) begin
            m_ii = w.instr; m_ip4 = w.pc4; m_iv = 1;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.stall = 0; bus.flush = 0;
        bus.branch_taken = 0; bus.branch_target = 0;
        bus.jump = 0; bus.jump_target = 0;
        bus.imem_ready = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        quiet_inputs();
        step();
        step();
        if ({bus.imem_req, bus.imem_addr, bus.pc} !== {1'b0, RPC, RPC}) begin
            failures++;
            $display("FAIL reset_pc got req=%b addr=%h pc=%h exp req=0 addr=%h pc=%h",
                     bus.imem_req, bus.imem_addr, bus.pc, RPC, RPC);
        end
        checks++;
        if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_4} !== {1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_ifid got v=%b i=%h p=%h exp all zero",
                     bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_4);
        end
        checks++;
        rst = 0;
        step();
        if ({bus.imem_req, bus.imem_addr, bus.ifid_valid} !== {1'b1, RPC, 1'b0}) begin
            failures++;
            $display("FAIL first_req got req=%b addr=%h v=%b exp req=1 addr=%h v=0",
                     bus.imem_req, bus.imem_addr, bus.ifid_valid, RPC);
        end
        checks++;
        step();
        if ({bus.imem_addr, bus.ifid_valid, bus.ifid_pc_4, bus.ifid_instr}
            !== {RPC + 32'd4, 1'b1, RPC + 32'd4, mem_word(RPC)}) begin
            failures++;
            $display("FAIL cycle2 got addr=%h v=%b p=%h i=%h exp addr=%h v=1 p=%h i=%h",
                     bus.imem_addr, bus.ifid_valid, bus.ifid_pc_4, bus.ifid_instr,
                     RPC + 32'd4, RPC + 32'd4, mem_word(RPC));
        end
        checks++;
        step();
        if ({bus.imem_addr, bus.ifid_pc_4} !== {RPC + 32'd8, RPC + 32'd8}) begin
            failures++;
            $display("FAIL cycle3 got addr=%h p=%h exp %h %h",
                     bus.imem_addr, bus.ifid_pc_4, RPC + 32'd8, RPC + 32'd8);
        end
        checks++;
    endtask

    task automatic test_stall_hold();
        logic [31:0] a, keep_p4, keep_i;
        a = m_pc; keep_p4 = m_ip4; keep_i = m_ii;
        bus.stall = 1; bus.imem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if ({bus.imem_req, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_4}
                !== {1'b0, 1'b1, keep_i, keep_p4}) begin
                failures++;
                $display("FAIL stall_hold[%0d] got req=%b v=%b i=%h p=%h exp req=0 v=1 i=%h p=%h",
                         i, bus.imem_req, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_4,
                         keep_i, keep_p4);
            end
            checks++;
        end
        bus.stall = 0;
        step();
        if ({bus.ifid_instr, bus.ifid_pc_4, bus.imem_req, bus.imem_addr}
            !== {mem_word(a), a + 32'd4, 1'b1, a + 32'd4}) begin
            failures++;
            $display("FAIL hold_release got i=%h p=%h req=%b addr=%h exp i=%h p=%h req=1 addr=%h",
                     bus.ifid_instr, bus.ifid_pc_4, bus.imem_req, bus.imem_addr,
                     mem_word(a), a + 32'd4, a + 32'd4);
        end
        checks++;
        step();
        if ({bus.ifid_instr, bus.ifid_pc_4} !== {mem_word(a + 32'd4), a + 32'd8}) begin
            failures++;
            $display("FAIL hold_next got i=%h p=%h exp i=%h p=%h",
                     bus.ifid_instr, bus.ifid_pc_4, mem_word(a + 32'd4), a + 32'd8);
        end
        checks++;
    endtask

    task automatic test_redirect();
        logic [31:0] keep_p4, keep_i, a;
        keep_p4 = m_ip4; keep_i = m_ii;
        bus.branch_taken = 1; bus.branch_target = 32'h0000_0102;
        bus.jump = 1; bus.jump_target = 32'h0000_0200;
        bus.imem_ready = 1;
        step();
        if ({bus.imem_addr, bus.ifid_instr, bus.ifid_pc_4} !== {32'h0000_0100, keep_i, keep_p4}) begin
            failures++;
            $display("FAIL branch_redirect got addr=%h i=%h p=%h exp addr=00000100 i=%h p=%h",
                     bus.imem_addr, bus.ifid_instr, bus.ifid_pc_4, keep_i, keep_p4);
        end
        checks++;
        quiet_inputs();
        step();
        if ({bus.ifid_instr, bus.ifid_pc_4, bus.imem_addr}
            !== {mem_word(32'h100), 32'h0000_0104, 32'h0000_0104}) begin
            failures++;
            $display("FAIL after_branch got i=%h p=%h addr=%h exp i=%h p=00000104 addr=00000104",
                     bus.ifid_instr, bus.ifid_pc_4, bus.imem_addr, mem_word(32'h100));
        end
        checks++;
        // Jump out of HOLD: buffered word must be dropped.
        a = m_pc;
        bus.stall = 1;
        step();
        bus.jump = 1; bus.jump_target = 32'h0000_0302;
        step();
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_0300}) begin
            failures++;
            $display("FAIL hold_jump got req=%b addr=%h exp req=1 addr=00000300",
                     bus.imem_req, bus.imem_addr);
        end
        checks++;
        quiet_inputs();
        step();
        if ({bus.ifid_instr, bus.ifid_pc_4} !== {mem_word(32'h300), 32'h0000_0304}) begin
            failures++;
            $display("FAIL hold_jump_drop got i=%h p=%h exp i=%h p=00000304 (dropped word for %h)",
                     bus.ifid_instr, bus.ifid_pc_4, mem_word(32'h300), a);
        end
        checks++;
    endtask

    task automatic test_flush_stall();
        bus.stall = 1; bus.flush = 1; bus.imem_ready = 1;
        step();
        if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_4} !== {1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL flush_stall got v=%b i=%h p=%h exp all zero",
                     bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_4);
        end
        checks++;
        quiet_inputs();
        step();
        if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_4} !== {m_iv, m_ii, m_ip4}) begin
            failures++;
            $display("FAIL flush_release got v=%b i=%h p=%h exp v=%b i=%h p=%h",
                     bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_4, m_iv, m_ii, m_ip4);
        end
        checks++;
    endtask

    task automatic test_wrap();
        bus.jump = 1; bus.jump_target = 32'hFFFF_FFFF;
        step();
        if (bus.pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_setup got pc=%h exp pc=fffffffc", bus.pc);
        end
        checks++;
        quiet_inputs();
        step();
        if ({bus.pc, bus.ifid_valid, bus.ifid_pc_4, bus.ifid_instr}
            !== {32'h0, 1'b1, 32'h0, mem_word(32'hFFFF_FFFC)}) begin
            failures++;
            $display("FAIL pc_wrap got pc=%h v=%b p=%h i=%h exp pc=0 v=1 p=0 i=%h",
                     bus.pc, bus.ifid_valid, bus.ifid_pc_4, bus.ifid_instr,
                     mem_word(32'hFFFF_FFFC));
        end
        checks++;
    endtask

    task automatic test_reset_in_hold();
        bus.stall = 1; bus.imem_ready = 1;
        step();
        if (bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL enter_hold got req=%b exp req=0", bus.imem_req);
        end
        checks++;
        rst = 1;
        step();
        if ({bus.imem_req, bus.imem_addr, bus.pc, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_4}
            !== {1'b0, RPC, RPC, 1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_in_hold got req=%b addr=%h pc=%h v=%b i=%h p=%h exp reset values",
                     bus.imem_req, bus.imem_addr, bus.pc, bus.ifid_valid, bus.ifid_instr,
                     bus.ifid_pc_4);
        end
        checks++;
        rst = 0; bus.stall = 0;
        step();
        if ({bus.imem_req, bus.imem_addr, bus.ifid_valid} !== {1'b1, RPC, 1'b0}) begin
            failures++;
            $display("FAIL post_hold_reset got req=%b addr=%h v=%b exp req=1 addr=%h v=0",
                     bus.imem_req, bus.imem_addr, bus.ifid_valid, RPC);
        end
        checks++;
        step();
        if ({bus.ifid_instr, bus.ifid_pc_4} !== {mem_word(RPC), RPC + 32'd4}) begin
            failures++;
            $display("FAIL post_hold_first got i=%h p=%h exp i=%h p=%h",
                     bus.ifid_instr, bus.ifid_pc_4, mem_word(RPC), RPC + 32'd4);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            rst              = ($urandom_range(99) == 0);
            bus.stall        = ($urandom_range(3) == 0);
            bus.flush        = ($urandom_range(9) == 0);
            bus.imem_ready   = ($urandom_range(9) < 7);
            bus.branch_taken = ($urandom_range(19) == 0);
            bus.jump         = ($urandom_range(19) == 0);
            bus.branch_target = $urandom;
            bus.jump_target   = $urandom;
            step();
            if ({bus.imem_req, bus.imem_addr, bus.pc, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc_4}
                !== {m_req(), m_pc, m_pc, m_iv, m_ii, m_ip4}) begin
                failures++;
                $display("FAIL random[%0d] got req=%b addr=%h pc=%h v=%b i=%h p=%h exp req=%b addr=%h pc=%h v=%b i=%h p=%h",
                         n, bus.imem_req, bus.imem_addr, bus.pc, bus.ifid_valid, bus.ifid_instr,
                         bus.ifid_pc_4, m_req(), m_pc, m_pc, m_iv, m_ii, m_ip4);
            end
            checks++;
        end
        rst = 0;
        quiet_inputs();
    endtask

    initial begin
        test_reset();
        test_stall_hold();
        test_redirect();
        test_flush_stall();
        test_wrap();
        test_reset_in_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
